// File: rtl/dmem_copy_master.sv
// Word-copy engine that initiates tagged loads and in-order stores on the dmem request port.
// Up to MAX_OUT loads are in flight; a tag-indexed reorder buffer restores source order for stores.
module dmem_copy_master #(
   parameter int LDTAG_W = 4,
   parameter int MAX_OUT = 4,
   parameter int LEN_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_start,
   input  logic [31:0]        cfg_src,
   input  logic [31:0]        cfg_dst,
   input  logic [LEN_W-1:0]   cfg_len,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               m_req_valid,
   input  logic               m_req_ready,
   output logic               m_req_we,
   output logic [31:0]        m_req_addr,
   output logic [31:0]        m_req_wdata,
   output logic [3:0]         m_req_wstrb,
   output logic [LDTAG_W-1:0] m_req_tag,
   input  logic               m_ld_valid,
   input  logic [LDTAG_W-1:0] m_ld_tag,
   input  logic [31:0]        m_ld_data,
   input  logic               m_st_ack
);

   localparam int PTR_W = $clog2(MAX_OUT);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [1:0] FREE = 2'd0;
   localparam logic [1:0] PEND = 2'd1;
   localparam logic [1:0] FULL = 2'd2;

   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
   localparam logic [LEN_W:0]   ACK_ONE = (LEN_W+1)'(1);

   logic [1:0]       state;
   logic [31:0]      src_q, dst_q;
   logic [LEN_W-1:0] len_q, ld_cnt, st_cnt, st_nxt;
   logic [LEN_W:0]   ack_cnt, ack_nxt;
   logic [1:0]       slot_st   [MAX_OUT];
   logic [31:0]      slot_data [MAX_OUT];
   logic             hold_vld, hold_we;
   logic [PTR_W-1:0] ld_ptr, st_ptr, rsp_idx;
   logic             st_elig, ld_elig, req_vld, req_we;
   logic             hs, ld_hs, st_hs;
   logic             tag_oob, rsp_ok, rsp_bad, ack_over, finish;

   // Counters start at zero, so the slot pointers are simply their low bits.
   assign ld_ptr  = ld_cnt[PTR_W-1:0];
   assign st_ptr  = st_cnt[PTR_W-1:0];
   assign rsp_idx = m_ld_tag[PTR_W-1:0];

   assign st_elig = (state == RUN) && (slot_st[st_ptr] == FULL);
   assign ld_elig = (state == RUN) && (slot_st[ld_ptr] == FREE) && (ld_cnt != len_q);

   // A held request keeps its type; addresses and data cannot move until its handshake.
   assign req_vld = hold_vld | st_elig | ld_elig;
   assign req_we  = hold_vld ? hold_we : st_elig;
   assign hs      = req_vld & m_req_ready;
   assign ld_hs   = hs & ~req_we;
   assign st_hs   = hs & req_we;

   assign m_req_valid = req_vld;
   assign m_req_we    = req_vld & req_we;
   assign m_req_wstrb = {4{req_vld & req_we}};
   assign m_req_addr  = !req_vld ? 32'd0 :
                        req_we   ? dst_q + (32'(st_cnt) << 2) :
                                   src_q + (32'(ld_cnt) << 2);
   assign m_req_wdata = (req_vld && req_we) ? slot_data[st_ptr] : 32'd0;
   assign m_req_tag   = (req_vld && !req_we) ? LDTAG_W'(ld_ptr) : '0;

   assign tag_oob  = 32'(m_ld_tag) >= 32'(MAX_OUT);
   assign rsp_ok   = (state == RUN) && m_ld_valid && !tag_oob && (slot_st[rsp_idx] == PEND);
   assign rsp_bad  = (state == RUN) && m_ld_valid && (tag_oob || (slot_st[rsp_idx] != PEND));
   assign ack_over = (state == RUN) && m_st_ack && (ack_cnt >= {1'b0, len_q});

   assign st_nxt  = st_hs ? st_cnt + CNT_ONE : st_cnt;
   assign ack_nxt = (m_st_ack && ack_cnt != '1) ? ack_cnt + ACK_ONE : ack_cnt;
   assign finish  = (st_nxt == len_q) && (ack_nxt == {1'b0, len_q});

   assign busy = (state == CHECK) || (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         err      <= 1'b0;
         hold_vld <= 1'b0;
         hold_we  <= 1'b0;
         ld_cnt   <= '0;
         st_cnt   <= '0;
         ack_cnt  <= '0;
      end else begin
         case (state)
            IDLE: if (cfg_start) begin
               state    <= CHECK;
               err      <= 1'b0;
               hold_vld <= 1'b0;
               ld_cnt   <= '0;
               st_cnt   <= '0;
               ack_cnt  <= '0;
            end
            CHECK: begin
               if (src_q[1:0] != 2'b00 || dst_q[1:0] != 2'b00) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else if (len_q == '0) begin
                  state <= DONE;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (ld_hs) ld_cnt <= ld_cnt + CNT_ONE;
               st_cnt   <= st_nxt;
               ack_cnt  <= ack_nxt;
               hold_vld <= req_vld & ~m_req_ready;
               hold_we  <= req_we;
               if (rsp_bad || ack_over) err <= 1'b1;
               if (finish) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Copy parameters are only consumed after CHECK, so they need no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && cfg_start) begin
         src_q <= cfg_src;
         dst_q <= cfg_dst;
         len_q <= cfg_len;
      end
   end

   // Each event acts on a slot in a distinct state, so at most one applies per slot per cycle.
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && cfg_start)) begin
         for (int i = 0; i < MAX_OUT; i++) slot_st[i] <= FREE;
      end else begin
         for (int i = 0; i < MAX_OUT; i++) begin
            if (rsp_ok && rsp_idx == PTR_W'(i)) slot_st[i] <= FULL;
            if (ld_hs && ld_ptr == PTR_W'(i))   slot_st[i] <= PEND;
            if (st_hs && st_ptr == PTR_W'(i))   slot_st[i] <= FREE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rsp_ok) slot_data[rsp_idx] <= m_ld_data;
   end

endmodule

// File: tb/tb_dmem_copy_master.sv
// Bench for dmem_copy_master: a behavioural memory responder plus a word-list reference model.
module tb_dmem_copy_master;

   logic        clk, rst, cfg_start;
   logic [31:0] cfg_src, cfg_dst;
   logic [15:0] cfg_len;
   logic        busy, done, err;
   logic        m_req_valid, m_req_ready, m_req_we;
   logic [31:0] m_req_addr, m_req_wdata;
   logic [3:0]  m_req_wstrb, m_req_tag;
   logic        m_ld_valid;
   logic [3:0]  m_ld_tag;
   logic [31:0] m_ld_data;
   logic        m_st_ack;

   dmem_copy_master #(.LDTAG_W(4), .MAX_OUT(4), .LEN_W(16)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
      .cfg_len(cfg_len), .busy(busy), .done(done), .err(err),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
      .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
      .m_req_tag(m_req_tag), .m_ld_valid(m_ld_valid), .m_ld_tag(m_ld_tag),
      .m_ld_data(m_ld_data), .m_st_ack(m_st_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] data;
      int          due;
   } rsp_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] seed;
   int          resp_mode = 0;   // 0 in order, 1 grouped 2,0,3,1, 2 random, 3 withheld
   int          ready_mode = 0;  // 0 always ready, 1 random, 2 never
   bit          spur_arm = 0;
   int          done_cnt = 0, done_cyc = -1, first_vld_cyc = -1, last_ack_cyc = -1;
   int          vld_seen = 0, inflight = 0, max_inflight = 0;
   int          perm [4];
   rsp_t        pend[$], rel[$];
   int          ack_q[$];
   logic [31:0] ld_addr_q[$], st_addr_q[$], st_data_q[$];
   int          ld_tag_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] src_word(input logic [31:0] a);
      return a * 32'h9E37_79B1 + seed;
   endfunction

   // Memory responder: the only process that drives the DUT's m_* inputs.
   initial begin : responder
      bit          stall_prev, sent, rdy;
      logic        sv_we;
      logic [31:0] sv_addr, sv_wdata;
      logic [3:0]  sv_wstrb, sv_tag;
      rsp_t        r;
      int          idx;
      perm = '{2, 0, 3, 1};
      stall_prev = 0;
      m_req_ready = 0; m_ld_valid = 0; m_ld_tag = 0; m_ld_data = 0; m_st_ack = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (m_req_valid) vld_seen++;
         if (m_req_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
         if (stall_prev && !rst) begin
            check("hold_valid", m_req_valid, 1);
            check("hold_we", m_req_we, sv_we);
            check("hold_addr", m_req_addr, sv_addr);
            check("hold_wdata", m_req_wdata, sv_wdata);
            check("hold_wstrb", m_req_wstrb, sv_wstrb);
            check("hold_tag", m_req_tag, sv_tag);
         end
         case (ready_mode)
            0:       rdy = 1;
            1:       rdy = ($urandom_range(0, 1) == 1);
            default: rdy = 0;
         endcase
         m_req_ready = rdy;
         if (m_req_valid && rdy) begin
            if (m_req_we) begin
               check("st_wstrb", m_req_wstrb, 4'hF);
               check("st_tag", m_req_tag, 0);
               st_addr_q.push_back(m_req_addr);
               st_data_q.push_back(m_req_wdata);
               ack_q.push_back(cyc + 1 + ((resp_mode == 2) ? $urandom_range(0, 2) : 0));
            end else begin
               check("ld_wstrb", m_req_wstrb, 4'h0);
               ld_addr_q.push_back(m_req_addr);
               ld_tag_q.push_back(int'(m_req_tag));
               r.tag  = m_req_tag;
               r.data = src_word(m_req_addr);
               r.due  = cyc + ((resp_mode == 2) ? $urandom_range(1, 4) : 2);
               pend.push_back(r);
               inflight++;
               if (inflight > max_inflight) max_inflight = inflight;
            end
         end
         stall_prev = m_req_valid && !rdy;
         sv_we = m_req_we; sv_addr = m_req_addr; sv_wdata = m_req_wdata;
         sv_wstrb = m_req_wstrb; sv_tag = m_req_tag;

         sent = 0;
         case (resp_mode)
            0: if (pend.size() > 0 && pend[0].due <= cyc) begin
                  r = pend.pop_front(); sent = 1;
               end
            1: begin
                  if (rel.size() == 0 && pend.size() == 4) begin
                     for (int p = 0; p < 4; p++)
                        for (int q = 0; q < 4; q++)
                           if (int'(pend[q].tag) == perm[p]) rel.push_back(pend[q]);
                     pend.delete();
                  end
                  if (rel.size() > 0 && rel[0].due <= cyc) begin
                     r = rel.pop_front(); sent = 1;
                  end
               end
            2: if (pend.size() > 0) begin
                  idx = $urandom_range(0, pend.size() - 1);
                  if (pend[idx].due <= cyc && $urandom_range(0, 1) == 1) begin
                     r = pend[idx]; pend.delete(idx); sent = 1;
                  end
               end
            default: ;
         endcase
         m_ld_valid = 0; m_ld_tag = 0; m_ld_data = 0;
         if (sent) begin
            m_ld_valid = 1; m_ld_tag = r.tag; m_ld_data = r.data; inflight--;
         end else if (spur_arm && m_req_valid) begin
            m_ld_valid = 1; m_ld_tag = 4'd3; m_ld_data = 32'hDEAD_BEEF; spur_arm = 0;
         end
         m_st_ack = 0;
         if (ack_q.size() > 0 && ack_q[0] <= cyc) begin
            void'(ack_q.pop_front());
            m_st_ack = 1;
            last_ack_cyc = cyc;
         end
      end
   end

   task automatic clear_logs();
      ld_addr_q.delete(); ld_tag_q.delete(); st_addr_q.delete(); st_data_q.delete();
      inflight = 0; max_inflight = 0; first_vld_cyc = -1; vld_seen = 0;
   endtask

   task automatic run_copy(input string nm, input logic [31:0] src, input logic [31:0] dst,
                           input int len, input logic exp_err);
      int  start_cyc, d0;
      bit  got;
      clear_logs();
      @(negedge clk); #1;
      cfg_src = src; cfg_dst = dst; cfg_len = 16'(len); cfg_start = 1;
      start_cyc = cyc; d0 = done_cnt;
      @(negedge clk); #1;
      cfg_start = 0;
      check({nm, "_busy_check"}, busy, 1);
      check({nm, "_err_clr"}, err, 0);
      got = 0;
      for (int i = 0; i < 4000; i++) begin
         if (done_cnt != d0) begin got = 1; break; end
         @(negedge clk); #1;
      end
      check({nm, "_done_seen"}, got, 1);
      if (!got) return;
      check({nm, "_busy_at_done"}, busy, 0);
      if (len == 0) begin
         check({nm, "_done_lat"}, done_cyc, start_cyc + 2);
         check({nm, "_no_req"}, vld_seen, 0);
      end else begin
         check({nm, "_first_vld"}, first_vld_cyc, start_cyc + 2);
         check({nm, "_done_after_ack"}, done_cyc, last_ack_cyc + 1);
      end
      repeat (3) @(negedge clk); #1;
      check({nm, "_done_once"}, done_cnt - d0, 1);
      check({nm, "_err"}, err, exp_err);
      check({nm, "_busy_after"}, busy, 0);
      check({nm, "_inflight_max_ok"}, (max_inflight <= 4), 1);
      check({nm, "_n_loads"}, ld_addr_q.size(), len);
      check({nm, "_n_stores"}, st_addr_q.size(), len);
      for (int i = 0; i < len && i < ld_addr_q.size(); i++) begin
         check($sformatf("%s_ld_addr%0d", nm, i), ld_addr_q[i], src + 32'(i) * 4);
         check($sformatf("%s_ld_tag%0d", nm, i), ld_tag_q[i], i % 4);
      end
      for (int i = 0; i < len && i < st_addr_q.size(); i++) begin
         check($sformatf("%s_st_addr%0d", nm, i), st_addr_q[i], dst + 32'(i) * 4);
         check($sformatf("%s_st_data%0d", nm, i), st_data_q[i], src_word(src + 32'(i) * 4));
      end
   endtask

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int d0;
      bit got;
      seed = $urandom;
      rst = 1; cfg_start = 0; cfg_src = 0; cfg_dst = 0; cfg_len = 0;
      repeat (3) @(negedge clk); #1;
      check("rst_valid", m_req_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_addr", m_req_addr, 0);
      check("rst_wstrb", m_req_wstrb, 0);
      rst = 0;

      resp_mode = 0; ready_mode = 0;
      run_copy("basic", 32'h1000, 32'h2000, 3, 1'b0);

      resp_mode = 1;
      run_copy("reorder", 32'h5000, 32'h6000, 8, 1'b0);
      check("reorder_max_inflight", max_inflight, 4);

      resp_mode = 0; ready_mode = 1;
      run_copy("stall", 32'h0000_8000, 32'h0000_9000, 12, 1'b0);

      resp_mode = 0; ready_mode = 0;
      run_copy("wrap", 32'hFFFF_FFF8, 32'h0000_0010, 4, 1'b0);

      // Misaligned source: error, nothing issued, no completion pulse.
      clear_logs();
      d0 = done_cnt;
      @(negedge clk); #1;
      cfg_src = 32'h1002; cfg_dst = 32'h2000; cfg_len = 16'd4; cfg_start = 1;
      @(negedge clk); #1;
      cfg_start = 0;
      repeat (5) @(negedge clk); #1;
      check("misalign_err", err, 1);
      check("misalign_vld", vld_seen, 0);
      check("misalign_done", done_cnt - d0, 0);
      check("misalign_busy", busy, 0);
      run_copy("zero_len", 32'h1000, 32'h2000, 0, 1'b0);

      spur_arm = 1;
      run_copy("spurious", 32'h7000, 32'h7800, 6, 1'b1);

      for (int r = 0; r < 3; r++) begin
         resp_mode = 2; ready_mode = 1;
         run_copy($sformatf("rand%0d", r), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(1, 40), 1'b0);
      end

      // Reset while two loads are outstanding.
      resp_mode = 3; ready_mode = 0;
      clear_logs();
      @(negedge clk); #1;
      cfg_src = 32'h3000; cfg_dst = 32'h4000; cfg_len = 16'd8; cfg_start = 1;
      @(negedge clk); #1;
      cfg_start = 0;
      got = 0;
      for (int i = 0; i < 50; i++) begin
         if (ld_addr_q.size() >= 2) begin got = 1; break; end
         @(negedge clk); #1;
      end
      check("rstrun_two_loads", got, 1);
      ready_mode = 2;
      @(negedge clk); #1;
      check("rstrun_pending", ld_addr_q.size(), 2);
      check("rstrun_busy_before", busy, 1);
      rst = 1;
      @(negedge clk); #1;
      rst = 0;
      check("rstrun_valid", m_req_valid, 0);
      check("rstrun_busy", busy, 0);
      check("rstrun_done", done, 0);
      check("rstrun_err", err, 0);
      check("rstrun_addr", m_req_addr, 0);
      check("rstrun_wdata", m_req_wdata, 0);
      check("rstrun_wstrb", m_req_wstrb, 0);
      check("rstrun_tag", m_req_tag, 0);
      check("rstrun_we", m_req_we, 0);
      resp_mode = 0;
      repeat (6) @(negedge clk); #1;
      check("late_rsp_drained", pend.size(), 0);
      check("late_rsp_err", err, 0);
      check("late_rsp_busy", busy, 0);
      ready_mode = 0;
      run_copy("after_rst", 32'h3000, 32'h4000, 5, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_copy_master.md
Name: dmem_copy_master

Overview:
- Tagged-load memory-to-memory copy engine acting as an initiator (master) on the data-memory request/response protocol; the counterpart of the memory/MMIO responder side.
- Copies cfg_len 32-bit words from cfg_src to cfg_dst, either memory to memory or memory to an MMIO FIFO (for example, framebuffer to SPI TX).
- Keeps up to MAX_OUT loads in flight and commits stores strictly in order through a tag-indexed reorder buffer.

Parameters:
- LDTAG_W, 4, width of the load tag field.
- MAX_OUT, 4, maximum outstanding loads and number of reorder-buffer slots. Must be a power of two and no more than 2**LDTAG_W.
- LEN_W, 16, width of the word-count field.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  start pulse; sampled only in IDLE.
- cfg_src  in  32  source byte address; must be word-aligned.
- cfg_dst  in  32  destination byte address; must be word-aligned.
- cfg_len  in  LEN_W  number of words to copy.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared by the next accepted cfg_start.
- m_req_valid  out  1  request valid.
- m_req_ready  in  1  responder accepts the request when valid and ready are both high.
- m_req_we  out  1  1 = store, 0 = load.
- m_req_addr  out  32  request byte address.
- m_req_wdata  out  32  store data.
- m_req_wstrb  out  4  byte enables; always 4'hF for stores, 4'h0 for loads.
- m_req_tag  out  LDTAG_W  load tag, equal to the reorder-buffer slot index; 0 for stores.
- m_ld_valid  in  1  load response valid.
- m_ld_tag  in  LDTAG_W  tag of the load response.
- m_ld_data  in  32  load response data.
- m_st_ack  in  1  one pulse per completed store.

Behaviour:
- Reset: rst sampled high at a clk edge returns the block to IDLE. All outputs go to 0, every slot is cleared and all counters go to 0.
- Reset mid-operation: any in-flight request is abandoned. Late responses arriving in IDLE are ignored and do not set err.
- States:
  - IDLE: cfg_start=1 goes to CHECK. cfg_start while busy is ignored.
  - CHECK (1 cycle): latch src, dst, len.
    - cfg_src[1:0]!=0 or cfg_dst[1:0]!=0: err=1, go to IDLE. No done pulse and no requests are issued.
    - len==0: go to DONE with no requests.
    - Otherwise go to RUN.
  - RUN: issue loads and stores, one request per cycle at most.
    - Go to DONE when stores issued == len and store acks == len.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- busy is 1 in CHECK and RUN, and 0 in IDLE and DONE.
- Reorder buffer: MAX_OUT slots, each with states FREE, PEND and FULL, plus a 32-bit data register.
  - Load pointer and store pointer wrap modulo MAX_OUT.
- Load issue: allowed when the slot at the load pointer is FREE and loads issued < len.
  - addr = src + 4*ld_idx, with 32-bit wrap-around; tag = load pointer.
  - On handshake: slot becomes PEND, load pointer and ld_idx increment.
- Load response: m_ld_valid with the slot at m_ld_tag in PEND stores the data and sets the slot to FULL.
  - Responses may arrive in any order.
  - A response to a slot that is not PEND, or with m_ld_tag >= MAX_OUT, sets err=1, drops the data and lets the copy continue.
- Store issue: allowed when the slot at the store pointer is FULL.
  - addr = dst + 4*st_idx, wdata = slot data.
  - On handshake: slot becomes FREE and the store pointer increments.
  - A slot freed in cycle N is reusable by a load in cycle N+1.
- Arbitration: when both are eligible, the store wins, so a full buffer cannot deadlock.
- Request stability: once m_req_valid is high, addr, we, wdata, wstrb and tag are held stable until the handshake.
  - The arbitration decision is not revisited while valid is high.
- Simultaneous events in one cycle are all applied: load response, request handshake and m_st_ack.
- Store-ack counter: saturating LEN_W+1 bits. An m_st_ack beyond len sets err.
- Latency:
  - First m_req_valid (a load) rises 2 cycles after the cfg_start cycle.
  - done rises 1 cycle after the final m_st_ack.
- cfg_len = 2**LEN_W-1 must complete without counter overflow.

Test Plan:
- src=0x1000, dst=0x2000, len=3, memory returns loads after 2 cycles in order, ready always 1 -> 3 loads with tags 0,1,2, then stores to 0x2000/4/8 with matching data; done pulses once; busy drops at done; err=0.
- len=8, MAX_OUT=4, load responses returned in order tag 2,0,3,1 -> stores still commit to dst+0..dst+28 in source order; never more than 4 loads in flight.
- m_req_ready toggled pseudo-randomly -> every request's fields are held stable while valid=1 and ready=0; data copy is intact.
- cfg_src=0x1002 -> err=1, no m_req_valid, no done. Then a valid start with len=0 -> err cleared, done pulses 2 cycles after start, no requests.
- Spurious m_ld_valid with tag 3 while slot 3 is FREE -> err=1; the copy still completes with correct data.
- rst asserted in RUN with 2 loads pending -> next cycle: all outputs 0 and state IDLE; late m_ld_valid ignored and err stays 0; a new copy afterwards completes correctly.
